mem_arbiter: RTL and testbench

- Shares the single memory/cache port between the controller's instruction-fetch path (F) and its load/store data path (D).
- Sits between the controller/datapath and the memory.
- Serialises accesses and holds the granted request stable while memory reports busy.
- Returns read data with a one-cycle ack pulse to the winner.
- Data has priority; a starvation counter guarantees fetch progress.

---
 rtl/ctrl_pkg.sv | 17 +
 rtl/arb_pick.sv | 31 +++
 rtl/mem_arbiter.sv | 100 ++++++++++
 tb/tb_mem_arbiter.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared types for the memory-port arbiter: FSM states and grant encoding.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_t;

  typedef enum logic {
    GNT_F = 1'b0,
    GNT_D = 1'b1
  } grant_t;

endpackage

// File: rtl/arb_pick.sv
// Priority pick between fetch and data requesters with a starvation guard for fetch.
// Latency: purely combinational; the caller registers grant and counter.
// Backpressure: none here; the caller applies the result only while arbitrating.
module arb_pick
  import ctrl_pkg::*;
#(
  parameter int STARVE = 4,
  parameter int CW     = $clog2(STARVE + 1)
) (
  input  logic          f_req,
  input  logic          d_req,
  input  logic [CW-1:0] starve_cnt,
  output grant_t        grant,
  output logic [CW-1:0] starve_nxt
);

  localparam logic [CW-1:0] CMAX = CW'(STARVE);

  // Data wins unless fetch is waiting and has already lost STARVE times in a row.
  always_comb begin
    grant      = GNT_F;
    starve_nxt = '0;
    if (d_req && !(f_req && (starve_cnt == CMAX))) begin
      grant = GNT_D;
      if (f_req) begin
        starve_nxt = (starve_cnt == CMAX) ? CMAX : starve_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises fetch (F) and load/store (D) accesses onto one memory port, D first.
// Latency: IDLE -> ACCESS -> ACK; ack pulses one cycle after the first non-busy ACCESS cycle.
// Backpressure: mem_busy holds ACCESS with stable address/data; new requests wait in IDLE.
module mem_arbiter
  import ctrl_pkg::*;
#(
  parameter int NBITS  = 8,
  parameter int STARVE = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             f_req,
  input  logic [NBITS-1:0] f_addr,
  output logic             f_ack,
  output logic [NBITS-1:0] f_rdata,
  input  logic             d_req,
  input  logic             d_we,
  input  logic [NBITS-1:0] d_addr,
  input  logic [NBITS-1:0] d_wdata,
  output logic             d_ack,
  output logic [NBITS-1:0] d_rdata,
  output logic             mem_req,
  output logic             mem_we,
  output logic [NBITS-1:0] mem_addr,
  output logic [NBITS-1:0] mem_wdata,
  input  logic             mem_busy,
  input  logic [NBITS-1:0] mem_rdata
);

  localparam int CW = $clog2(STARVE + 1);

  state_t        state;
  grant_t        grant_q;
  logic [CW-1:0] starve_cnt;
  grant_t        pick_grant;
  logic [CW-1:0] starve_nxt;

  arb_pick #(
    .STARVE (STARVE),
    .CW     (CW)
  ) u_pick (
    .f_req      (f_req),
    .d_req      (d_req),
    .starve_cnt (starve_cnt),
    .grant      (pick_grant),
    .starve_nxt (starve_nxt)
  );

  // Arbitration FSM; the memory-side outputs double as the latched request registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      grant_q    <= GNT_F;
      starve_cnt <= '0;
      f_ack      <= 1'b0;
      d_ack      <= 1'b0;
      f_rdata    <= '0;
      d_rdata    <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      f_ack <= 1'b0;
      d_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (f_req || d_req) begin
            grant_q    <= pick_grant;
            starve_cnt <= starve_nxt;
            mem_req    <= 1'b1;
            // Fetches are always reads, so the store strobe only passes for a D grant.
            mem_we     <= (pick_grant == GNT_D) && d_we;
            mem_addr   <= (pick_grant == GNT_D) ? d_addr : f_addr;
            mem_wdata  <= (pick_grant == GNT_D) ? d_wdata : '0;
            state      <= ACCESS;
          end
        end
        ACCESS: begin
          if (!mem_busy) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (grant_q == GNT_D) begin
              d_ack   <= 1'b1;
              d_rdata <= mem_we ? '0 : mem_rdata;
            end else begin
              f_ack   <= 1'b1;
              f_rdata <= mem_rdata;
            end
            state <= ACK;
          end
        end
        // One dead cycle so the requester can drop or change its request.
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: transaction model compared every cycle plus directed literals.
// Latency: n/a (testbench).
// Backpressure: a small memory model inserts a configurable number of busy cycles per access.
module tb_mem_arbiter;

  localparam int NBITS  = 8;
  localparam int STARVE = 4;

  logic             clock = 1'b0;
  logic             reset;
  logic             f_req = 1'b0;
  logic [NBITS-1:0] f_addr = '0;
  logic             f_ack;
  logic [NBITS-1:0] f_rdata;
  logic             d_req = 1'b0;
  logic             d_we = 1'b0;
  logic [NBITS-1:0] d_addr = '0;
  logic [NBITS-1:0] d_wdata = '0;
  logic             d_ack;
  logic [NBITS-1:0] d_rdata;
  logic             mem_req;
  logic             mem_we;
  logic [NBITS-1:0] mem_addr;
  logic [NBITS-1:0] mem_wdata;
  logic             mem_busy = 1'b0;
  logic [NBITS-1:0] mem_rdata = '0;

  int  checks = 0;
  int  failures = 0;
  bit  cmp_en = 1'b0;
  int  busy_cfg = 0;
  int  busy_used = 0;
  byte ack_q[$];

  mem_arbiter #(.NBITS(NBITS), .STARVE(STARVE)) dut (
    .clock     (clock),
    .reset     (reset),
    .f_req     (f_req),
    .f_addr    (f_addr),
    .f_ack     (f_ack),
    .f_rdata   (f_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_ack     (d_ack),
    .d_rdata   (d_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_busy  (mem_busy),
    .mem_rdata (mem_rdata)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic chk_str(input string name, input string act, input string exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=\"%s\" expected=\"%s\"", name, act, exp);
    end
  endtask

  function automatic string log_since(input int mark);
    string s = "";
    for (int i = mark; i < ack_q.size(); i++) s = {s, (ack_q[i] == "D") ? "D" : "F"};
    return s;
  endfunction

  // Memory: busy for busy_cfg cycles at the start of every access, then ready.
  always @(negedge clock) begin
    if (!mem_req) begin
      busy_used = 0;
      mem_busy  = 1'b0;
    end else begin
      mem_busy  = (busy_used < busy_cfg);
      busy_used = busy_used + 1;
    end
  end

  // Transaction model: one outstanding access at a time, tracked as phase
  // 0 = waiting for requests, 1 = occupying memory, 2 = acknowledging.
  int               m_phase;
  bit               m_is_d, m_we, e_fack, e_dack;
  logic [NBITS-1:0] m_addr, m_wdata, m_frd, m_drd;
  int               m_cnt;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_phase = 0; m_is_d = 0; m_we = 0; m_addr = '0; m_wdata = '0;
      m_frd = '0; m_drd = '0; m_cnt = 0; e_fack = 0; e_dack = 0;
    end else begin
      e_fack = 0;
      e_dack = 0;
      if (m_phase == 2) begin
        m_phase = 0;
      end else if (m_phase == 1) begin
        if (!mem_busy) begin
          if (m_is_d) begin
            m_drd  = m_we ? '0 : mem_rdata;
            e_dack = 1;
          end else begin
            m_frd  = mem_rdata;
            e_fack = 1;
          end
          m_phase = 2;
        end
      end else if (f_req || d_req) begin
        m_is_d  = d_req && !(f_req && m_cnt == STARVE);
        if (m_is_d && f_req) m_cnt = (m_cnt < STARVE) ? m_cnt + 1 : STARVE;
        else m_cnt = 0;
        m_we    = m_is_d && d_we;
        m_addr  = m_is_d ? d_addr : f_addr;
        m_wdata = d_wdata;
        m_phase = 1;
      end
    end
  end

  // Per-cycle comparison against the model, plus an ack log for ordering checks.
  always @(negedge clock) begin
    if (f_ack) ack_q.push_back("F");
    if (d_ack) ack_q.push_back("D");
    if (cmp_en) begin
      chk("cyc_f_ack", f_ack, e_fack);
      chk("cyc_d_ack", d_ack, e_dack);
      chk("cyc_mem_req", mem_req, m_phase == 1);
      chk("cyc_mem_we", mem_we, (m_phase == 1) && m_we);
      if (m_phase == 1) chk("cyc_mem_addr", mem_addr, m_addr);
      if (m_phase == 1 && m_we) chk("cyc_mem_wdata", mem_wdata, m_wdata);
      chk("cyc_f_rdata", f_rdata, m_frd);
      chk("cyc_d_rdata", d_rdata, m_drd);
      chk("cyc_starve", 32'(dut.starve_cnt), m_cnt);
    end
  end

  task automatic wait_ack(input string name, input int limit);
    bit got = 0;
    for (int i = 0; i < limit && !got; i++) begin
      @(negedge clock);
      if (f_ack || d_ack) got = 1;
    end
    chk(name, got, 1);
  endtask

  task automatic wait_mem_req(input string name, input int limit);
    bit got = 0;
    for (int i = 0; i < limit && !got; i++) begin
      @(negedge clock);
      if (mem_req) got = 1;
    end
    chk(name, got, 1);
  endtask

  initial begin
    int mark, acc, nack;
    reset = 1'b1;
    #1 reset = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_acks", {f_ack, d_ack}, 0);
    chk("rst_rdata", {f_rdata, d_rdata}, 0);
    reset  = 1'b1;
    cmp_en = 1'b1;

    // 1: fetch only, no wait states.
    @(negedge clock);
    mark = ack_q.size();
    f_req = 1; f_addr = 8'h10; mem_rdata = 8'h93; busy_cfg = 0;
    @(negedge clock);
    chk("t1_mem_req", mem_req, 1);
    chk("t1_mem_addr", mem_addr, 8'h10);
    chk("t1_mem_we", mem_we, 0);
    wait_ack("t1_ack_seen", 10);
    chk("t1_f_ack", f_ack, 1);
    chk("t1_f_rdata", f_rdata, 8'h93);
    chk("t1_d_ack", d_ack, 0);
    f_req = 0;
    repeat (3) @(negedge clock);
    chk_str("t1_log", log_since(mark), "F");

    // 2: store with three busy cycles.
    mark = ack_q.size();
    d_req = 1; d_we = 1; d_addr = 8'h20; d_wdata = 8'h5A; mem_rdata = 8'hEE; busy_cfg = 3;
    acc = 0;
    for (int i = 0; i < 20 && !d_ack; i++) begin
      @(negedge clock);
      if (mem_req) begin
        acc++;
        chk("t2_addr", mem_addr, 8'h20);
        chk("t2_wdata", mem_wdata, 8'h5A);
        chk("t2_we", mem_we, 1);
      end
    end
    chk("t2_d_ack", d_ack, 1);
    chk("t2_access_cycles", acc, 4);
    chk("t2_d_rdata", d_rdata, 0);
    d_req = 0; d_we = 0; busy_cfg = 0;
    repeat (2) @(negedge clock);
    chk_str("t2_log", log_since(mark), "D");

    // 3: simultaneous requests from idle: D first, then F.
    mark = ack_q.size();
    f_req = 1; f_addr = 8'h11; d_req = 1; d_addr = 8'h31; mem_rdata = 8'h42;
    nack = 0;
    for (int i = 0; i < 30 && nack < 2; i++) begin
      @(negedge clock);
      if (d_ack) begin
        nack++;
        chk("t3_d_rdata", d_rdata, 8'h42);
        chk("t3_cnt_after_d", 32'(dut.starve_cnt), 1);
        d_req = 0; mem_rdata = 8'h24;
      end
      if (f_ack) begin
        nack++;
        chk("t3_f_rdata", f_rdata, 8'h24);
        chk("t3_cnt_after_f", 32'(dut.starve_cnt), 0);
        f_req = 0;
      end
    end
    repeat (2) @(negedge clock);
    chk_str("t3_log", log_since(mark), "DF");

    // 4: D continuously requesting, F waiting: four D grants, then forced F.
    mark = ack_q.size();
    f_req = 1; f_addr = 8'h12; d_req = 1; d_addr = 8'h40; mem_rdata = 8'h01;
    nack = 0;
    for (int i = 0; i < 100 && nack < 6; i++) begin
      @(negedge clock);
      if (f_ack) f_req = 0;
      if (f_ack || d_ack) nack++;
    end
    d_req = 0;
    repeat (3) @(negedge clock);
    chk_str("t4_log", log_since(mark), "DDDDFD");

    // 5: reset in the middle of a stalled access.
    d_req = 1; d_we = 0; d_addr = 8'h50; busy_cfg = 100;
    wait_mem_req("t5_mem_req_seen", 10);
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    chk("t5_mem_req", mem_req, 0);
    chk("t5_mem_we_addr", {mem_we, mem_addr, mem_wdata}, 0);
    chk("t5_acks", {f_ack, d_ack}, 0);
    chk("t5_rdata", {f_rdata, d_rdata}, 0);
    d_req = 0; busy_cfg = 0;
    @(negedge clock);
    reset = 1'b1;
    mark = ack_q.size();
    repeat (6) @(negedge clock);
    chk_str("t5_no_ack", log_since(mark), "");
    d_req = 1; d_addr = 8'h44; mem_rdata = 8'h77;
    wait_ack("t5_fresh_ack_seen", 10);
    chk("t5_fresh_d_ack", d_ack, 1);
    chk("t5_fresh_d_rdata", d_rdata, 8'h77);
    d_req = 0;
    repeat (2) @(negedge clock);

    // 6: requester changes its address during ACCESS.
    d_req = 1; d_addr = 8'h20; mem_rdata = 8'h66; busy_cfg = 2;
    acc = 0;
    for (int i = 0; i < 20 && !d_ack; i++) begin
      @(negedge clock);
      if (mem_req) begin
        acc++;
        chk("t6_mem_addr", mem_addr, 8'h20);
        d_addr = 8'h30;
      end
    end
    chk("t6_d_ack", d_ack, 1);
    chk("t6_access_cycles", acc, 3);
    chk("t6_d_rdata", d_rdata, 8'h66);
    d_req = 0; busy_cfg = 0;
    repeat (3) @(negedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
